// File: rtl/inv_mixcol_seq.sv
// Iterative AES InvMixColumns engine: COLS_PER_CYCLE columns per cycle, valid/ready on both sides.
// Optional macro INV_MIXCOL_BYPASS_EN adds a per-block bypass (final decryption round).
module inv_mixcol_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef INV_MIXCOL_BYPASS_EN
    ,
    input  logic         bypass
`endif
);

    localparam int unsigned N_CYC = 4 / COLS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_data_q, out_data_d;
    logic         accept;
`ifdef INV_MIXCOL_BYPASS_EN
    logic         byp_q, byp_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant via shift-and-xor over its set bits.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = gmul(a[i], 4'he) ^ gmul(a[(i+1)%4], 4'hb)
                        ^ gmul(a[(i+2)%4], 4'hd) ^ gmul(a[(i+3)%4], 4'h9);
        end
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_data  = out_data_q;

    always_comb begin
        logic [1:0] col;
        state_d    = state_q;
        cnt_d      = cnt_q;
        st_d       = st_q;
        out_data_d = out_data_q;
        col        = 2'd0;
`ifdef INV_MIXCOL_BYPASS_EN
        byp_d      = byp_q;
`endif
        case (state_q)
            RUN: begin
`ifdef INV_MIXCOL_BYPASS_EN
                if (byp_q) begin
                    out_data_d = st_q;
                    state_d    = DONE;
                end else begin
`else
                begin
`endif
                    for (int unsigned l = 0; l < COLS_PER_CYCLE; l++) begin
                        col = 2'(32'(cnt_q) * COLS_PER_CYCLE + l);
                        st_d[{col, 5'd0} +: 32] = inv_col(st_q[{col, 5'd0} +: 32]);
                    end
                    cnt_d = cnt_q + 2'd1;
                    // Last slice: publish the state including this edge's columns.
                    if (cnt_q == 2'(N_CYC - 1)) begin
                        out_data_d = st_d;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            st_d    = in_data;
            cnt_d   = 2'd0;
            state_d = RUN;
`ifdef INV_MIXCOL_BYPASS_EN
            byp_d   = bypass;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            st_q       <= '0;
            out_data_q <= '0;
`ifdef INV_MIXCOL_BYPASS_EN
            byp_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            st_q       <= st_d;
            out_data_q <= out_data_d;
`ifdef INV_MIXCOL_BYPASS_EN
            byp_q      <= byp_d;
`endif
        end
    end

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Randomized self-checking bench for inv_mixcol_seq (COLS_PER_CYCLE 1, 2, 4 instances).
module tb_inv_mixcol_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic         in_ready2, out_valid2, busy2;
    logic [127:0] out_data2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_data4;
`ifdef INV_MIXCOL_BYPASS_EN
    logic         bypass = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] VEC_IN  = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] VEC_OUT = 128'hc6c6c6c6_01010101_5c220af2_455313db;

    always #5 clk = ~clk;

    inv_mixcol_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef INV_MIXCOL_BYPASS_EN
        , .bypass(bypass)
`endif
    );
    inv_mixcol_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2)
`ifdef INV_MIXCOL_BYPASS_EN
        , .bypass(bypass)
`endif
    );
    inv_mixcol_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
`ifdef INV_MIXCOL_BYPASS_EN
        , .bypass(bypass)
`endif
    );

    // Reference: carry-less polynomial product, then long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_inv_mixcols(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [127:0] o;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ ref_gf_mul(coef[k], a[(r+k)%4]);
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Accept one block from IDLE and wait (bounded) for out_valid with out_ready low.
    task automatic run_block(input logic [127:0] d, output logic [127:0] res, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_vectors();
        int lat;
        in_valid = 1'b1; in_data = VEC_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL vec_busy edge=%0d got=%b exp=1", lat, busy); end
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL vec_latency got=%0d exp=4", lat); end
        n_cmp++; if (out_data !== VEC_OUT) begin n_err++; $display("FAIL vec_data got=%h exp=%h", out_data, VEC_OUT); end
        release_out();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL vec_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [127:0] d, res, exp;
        int lat;
        for (int i = 0; i < 16; i++) begin
            d   = rand128();
            exp = ref_inv_mixcols(d);
            run_block(d, res, lat);
            n_cmp++; if (lat != 4) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d exp=4", i, lat); end
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, res, exp); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, res, exp;
        int lat;
        d   = rand128();
        exp = ref_inv_mixcols(d);
        run_block(d, res, lat);
        n_cmp++; if (res !== exp || lat != 4) begin
            n_err++; $display("FAIL bp_first got=%h lat=%0d exp=%h lat=4", res, lat, exp);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = rand128();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b busy=%b data=%h exp 1/0/0 %h",
                         i, out_valid, in_ready, busy, out_data, exp);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_out();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL bp_no_accept[%0d] out_valid=%b busy=%b exp 0/0", i, out_valid, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, ea, eb;
        int e;
        a  = rand128();
        b  = 128'h00000000_d6d7d5d5_00000000_d6d7d5d5;
        ea = ref_inv_mixcols(a);
        eb = 128'h00000000_d5d4d4d4_00000000_d5d4d4d4;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = a;
        @(posedge clk); #1;
        in_data = b;
        for (e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e < 4) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_a edge=%0d got=1 exp=0", e); end
            end
        end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== ea || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_first valid=%b ready=%b data=%h exp 1/1 %h", out_valid, in_ready, out_data, ea);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== ea) begin
            n_err++; $display("FAIL b2b_second_accept valid=%b busy=%b data=%h exp 0/1 %h", out_valid, busy, out_data, ea);
        end
        for (e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e < 4) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_b edge=%0d got=1 exp=0", e); end
            end
        end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== eb) begin
            n_err++; $display("FAIL b2b_second valid=%b data=%h exp 1 %h", out_valid, out_data, eb);
        end
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_cols_per_cycle();
        int lat1, lat2, lat4;
        logic [127:0] r1, r2, r4;
        lat1 = 0; lat2 = 0; lat4 = 0; r1 = '0; r2 = '0; r4 = '0;
        in_valid = 1'b1; in_data = VEC_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (out_valid  && lat1 == 0) begin lat1 = e; r1 = out_data;  end
            if (out_valid2 && lat2 == 0) begin lat2 = e; r2 = out_data2; end
            if (out_valid4 && lat4 == 0) begin lat4 = e; r4 = out_data4; end
        end
        n_cmp++; if (lat1 != 4 || r1 !== VEC_OUT) begin n_err++; $display("FAIL cpc1 lat=%0d data=%h exp 4 %h", lat1, r1, VEC_OUT); end
        n_cmp++; if (lat2 != 2 || r2 !== VEC_OUT) begin n_err++; $display("FAIL cpc2 lat=%0d data=%h exp 2 %h", lat2, r2, VEC_OUT); end
        n_cmp++; if (lat4 != 1 || r4 !== VEC_OUT) begin n_err++; $display("FAIL cpc4 lat=%0d data=%h exp 1 %h", lat4, r4, VEC_OUT); end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        in_valid = 1'b1; in_data = rand128();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            n_err++; $display("FAIL rst_async in_ready=%b out_valid=%b busy=%b data=%h exp 1/0/0/0",
                              in_ready, out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL rst_no_output got=valid_or_busy exp=idle"); end
    endtask

`ifdef INV_MIXCOL_BYPASS_EN
    task automatic test_bypass();
        logic [127:0] d, res;
        int lat;
        d = 128'h0123456789abcdeffedcba9876543210;
        bypass = 1'b1;
        run_block(d, res, lat);
        bypass = 1'b0;
        n_cmp++; if (lat != 1 || res !== d) begin n_err++; $display("FAIL bypass_on lat=%0d data=%h exp 1 %h", lat, res, d); end
        release_out();
        run_block(d, res, lat);
        n_cmp++; if (lat != 4 || res !== ref_inv_mixcols(d)) begin
            n_err++; $display("FAIL bypass_off lat=%0d data=%h exp 4 %h", lat, res, ref_inv_mixcols(d));
        end
        release_out();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_cols_per_cycle();
        test_reset_mid_run();
`ifdef INV_MIXCOL_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
